// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM encoding, bit-count constants and the
// PCF8574 default address also used by the LCD write path.
package i2c_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned ACK_BIT   = 9;

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic [3:0] ACK_POS  = 4'(ACK_BIT - 1);

  localparam logic [6:0] PCF8574_ADDR = 7'h27;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_IGNORE
  } state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus FILT-sample glitch filter for one bus line,
// with registered rise/fall pulses on the accepted level.
module i2c_line_filter #(
  parameter int unsigned FILT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned CW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [CW-1:0] LAST = CW'(FILT - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_line};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      // A new level is accepted only after FILT consecutive samples.
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_level <= r_sync[1];
        r_rise  <= r_sync[1];
        r_fall  <= ~r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_expander_target.sv
// PCF8574-style I2C target: address match, ACK, parallel write port
// and parallel read port returned on read transfers.
module i2c_expander_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  ADDR = PCF8574_ADDR,
  parameter int unsigned FILT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic [7:0] port_in,
  output logic [7:0] port_out,
  output logic       wr_strobe,
  output logic       rd_strobe,
  output logic       busy
);

  logic w_scl;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_sda;
  logic w_sda_rise;
  logic w_sda_fall;
  logic w_start;
  logic w_stop;

  i2c_line_filter #(.FILT(FILT)) u_scl (
    .clk     (clk),
    .rst     (rst),
    .i_line  (scl),
    .o_level (w_scl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_line_filter #(.FILT(FILT)) u_sda (
    .clk     (clk),
    .rst     (rst),
    .i_line  (sda_i),
    .o_level (w_sda),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_tx;
  logic       r_rw;
  logic       r_ackd;
  logic       r_oe;
  logic [7:0] r_port_out;
  logic       r_wr;
  logic       r_rd;
  logic       r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_tx       <= '0;
      r_rw       <= 1'b0;
      r_ackd     <= 1'b0;
      r_oe       <= 1'b0;
      r_port_out <= 8'hFF;
      r_wr       <= 1'b0;
      r_rd       <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_wr <= 1'b0;
      r_rd <= 1'b0;
      if (w_start) begin
        r_state <= S_ADDR;
        r_cnt   <= '0;
        r_oe    <= 1'b0;
        r_busy  <= 1'b0;
      end else if (w_stop) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_oe    <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift <= {r_shift[6:0], w_sda};
              r_cnt   <= r_cnt + 4'd1;
              if (r_cnt == LAST_BIT) begin
                r_cnt <= '0;
                r_rw  <= w_sda;
                if (r_shift[6:0] == ADDR) begin
                  r_state <= S_ADDR_ACK;
                  r_busy  <= 1'b1;
                end else begin
                  r_state <= S_IGNORE;
                end
              end
            end
          end
          // r_oe doubles as the ACK phase flag: 0 on entry.
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (!r_oe) begin
                r_oe <= 1'b1;
              end else if (r_rw) begin
                r_tx    <= {port_in[6:0], 1'b0};
                r_oe    <= ~port_in[7];
                r_rd    <= 1'b1;
                r_cnt   <= 4'd1;
                r_ackd  <= 1'b0;
                r_state <= S_RD_DATA;
              end else begin
                r_oe    <= 1'b0;
                r_state <= S_WR_DATA;
              end
            end
          end
          S_WR_DATA: begin
            if (w_scl_rise) begin
              r_shift <= {r_shift[6:0], w_sda};
              r_cnt   <= r_cnt + 4'd1;
              if (r_cnt == LAST_BIT) begin
                r_port_out <= {r_shift[6:0], w_sda};
                r_wr       <= 1'b1;
                r_cnt      <= '0;
                r_state    <= S_WR_ACK;
              end
            end
          end
          S_WR_ACK: begin
            if (w_scl_fall) begin
              if (!r_oe) begin
                r_oe <= 1'b1;
              end else begin
                r_oe    <= 1'b0;
                r_state <= S_WR_DATA;
              end
            end
          end
          S_RD_DATA: begin
            if (w_scl_fall) begin
              if (r_cnt == ACK_POS) begin
                r_oe    <= 1'b0;
                r_cnt   <= '0;
                r_ackd  <= 1'b0;
                r_state <= S_RD_ACK;
              end else begin
                r_oe  <= ~r_tx[7];
                r_tx  <= {r_tx[6:0], 1'b0};
                r_cnt <= r_cnt + 4'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (w_scl_rise) begin
              if (w_sda) begin
                r_state <= S_IGNORE;
                r_busy  <= 1'b0;
              end else begin
                r_ackd <= 1'b1;
              end
            end else if (w_scl_fall && r_ackd) begin
              r_tx    <= {port_in[6:0], 1'b0};
              r_oe    <= ~port_in[7];
              r_rd    <= 1'b1;
              r_cnt   <= 4'd1;
              r_ackd  <= 1'b0;
              r_state <= S_RD_DATA;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign sda_oe    = r_oe;
  assign port_out  = r_port_out;
  assign wr_strobe = r_wr;
  assign rd_strobe = r_rd;
  assign busy      = r_busy;

endmodule
